// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, stability-counter debounce,
// press/release pulses and an optional long-press pulse (enabled by BUTTON_COND_HOLD_EN).
module button_conditioner #(
    parameter int unsigned     N_CH          = 4,
    parameter int unsigned     STABLE_CYCLES = 500000,
    parameter longint unsigned HOLD_CYCLES   = 64'd100000000
) (
    input  logic            clk,
    input  logic            arst_i,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] hold_o
);

    localparam int unsigned    CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    if (N_CH < 1 || STABLE_CYCLES < 1 || STABLE_CYCLES > 32'd16777216 ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 64'd4294967296) begin : g_bad_params
        $error("button_conditioner: parameter out of range");
    end

`ifdef BUTTON_COND_HOLD_EN
    localparam int unsigned    HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(HOLD_CYCLES);
`endif

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [1:0]    sync;
        logic [CW-1:0] cnt;
        logic          level;
        logic          rise;
        logic          fall;

        always_ff @(posedge clk or posedge arst_i) begin
            if (arst_i) begin
                sync <= '0;
            end else begin
                sync <= {sync[0], btn_i[ch]};
            end
        end

        // Any return of sync[1] to the accepted level restarts the count.
        always_ff @(posedge clk or posedge arst_i) begin
            if (arst_i) begin
                cnt   <= '0;
                level <= 1'b0;
                rise  <= 1'b0;
                fall  <= 1'b0;
            end else begin
                rise <= 1'b0;
                fall <= 1'b0;
                if (sync[1] == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    level <= sync[1];
                    rise  <= sync[1];
                    fall  <= ~sync[1];
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end

        assign level_o[ch] = level;
        assign rise_o[ch]  = rise;
        assign fall_o[ch]  = fall;

`ifdef BUTTON_COND_HOLD_EN
        logic [HW-1:0] hcnt;
        logic          hold;

        // Saturating at HOLD_CYCLES keeps the HOLD_LAST match to a single pulse per press.
        always_ff @(posedge clk or posedge arst_i) begin
            if (arst_i) begin
                hcnt <= '0;
                hold <= 1'b0;
            end else begin
                hold <= level && (hcnt == HOLD_LAST);
                if (!level) begin
                    hcnt <= '0;
                end else if (hcnt != HOLD_MAX) begin
                    hcnt <= hcnt + HW'(1);
                end
            end
        end

        assign hold_o[ch] = hold;
`else
        assign hold_o[ch] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with N_CH=4, STABLE_CYCLES=4, HOLD_CYCLES=10;
// long-press expectations follow whether BUTTON_COND_HOLD_EN is defined.
module tb_button_conditioner;

    localparam int unsigned     N_CH = 4;
    localparam int unsigned     S    = 4;
    localparam longint unsigned H    = 10;
`ifdef BUTTON_COND_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic            clk;
    logic            arst_i;
    logic [N_CH-1:0] btn_i;
    logic [N_CH-1:0] level_o;
    logic [N_CH-1:0] rise_o;
    logic [N_CH-1:0] fall_o;
    logic [N_CH-1:0] hold_o;

    int n_total;
    int n_bad;
    int n_rise1;
    logic [N_CH-1:0] acc_level;
    logic [N_CH-1:0] acc_rise;
    logic [N_CH-1:0] acc_fall;
    logic [N_CH-1:0] acc_hold;

    button_conditioner #(
        .N_CH         (N_CH),
        .STABLE_CYCLES(S),
        .HOLD_CYCLES  (H)
    ) dut (
        .clk    (clk),
        .arst_i (arst_i),
        .btn_i  (btn_i),
        .level_o(level_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .hold_o (hold_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_acc();
        acc_level = '0;
        acc_rise  = '0;
        acc_fall  = '0;
        acc_hold  = '0;
        n_rise1   = 0;
    endtask

    // Advance n rising edges; sample 1 time unit after each edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            acc_level |= level_o;
            acc_rise  |= rise_o;
            acc_fall  |= fall_o;
            acc_hold  |= hold_o;
            if (rise_o[1]) n_rise1++;
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        clear_acc();
        btn_i  = '0;
        arst_i = 1'b1;
        #1;
        check("rst_level", level_o, 4'h0);
        check("rst_rise",  rise_o,  4'h0);
        check("rst_fall",  fall_o,  4'h0);
        check("rst_hold",  hold_o,  4'h0);
        run(2);
        arst_i = 1'b0;

        // Reset with all buttons held high
        btn_i = 4'hF;
        run(20);
        check("pre_rst_level", level_o, 4'hF);
        arst_i = 1'b1;
        #1;
        check("async_rst_level", level_o, 4'h0);
        check("async_rst_rise",  rise_o,  4'h0);
        check("async_rst_fall",  fall_o,  4'h0);
        check("async_rst_hold",  hold_o,  4'h0);
        run(3);
        arst_i = 1'b0;
        run(5);
        check("post_rst_level_e5", level_o, 4'h0);
        check("post_rst_rise_e5",  rise_o,  4'h0);
        run(1);
        check("post_rst_level_e6", level_o, 4'hF);
        check("post_rst_rise_e6",  rise_o,  4'hF);
        run(1);
        check("post_rst_rise_e7", rise_o, 4'h0);
        run(8);
        check("post_rst_hold_t9", hold_o, 4'h0);
        run(1);
        check("post_rst_hold_t10", hold_o, HOLD_EN ? 4'hF : 4'h0);
        run(1);
        check("post_rst_hold_t11", hold_o, 4'h0);
        btn_i = 4'h0;
        run(5);
        check("all_rel_fall_e5", fall_o, 4'h0);
        run(1);
        check("all_rel_fall_e6",  fall_o,  4'hF);
        check("all_rel_level_e6", level_o, 4'h0);
        run(1);
        check("all_rel_fall_e7", fall_o, 4'h0);

        // Clean press on channel 0, held 40 cycles
        btn_i = 4'h1;
        clear_acc();
        run(5);
        check("press_level_e5", level_o, 4'h0);
        run(1);
        check("press_level_e6", level_o, 4'h1);
        check("press_rise_e6",  rise_o,  4'h1);
        run(1);
        check("press_rise_e7", rise_o, 4'h0);
        run(8);
        check("press_hold_t9", hold_o, 4'h0);
        run(1);
        check("press_hold_t10", hold_o, HOLD_EN ? 4'h1 : 4'h0);
        clear_acc();
        run(23);
        check("press_no_more_hold", acc_hold,  4'h0);
        check("press_no_more_rise", acc_rise,  4'h0);
        check("press_others_quiet", acc_level, 4'h1);

        // Glitch of 3 cycles on channel 1
        clear_acc();
        btn_i = 4'h3;
        run(3);
        btn_i = 4'h1;
        run(10);
        check("glitch_ch1_quiet", {acc_level[1], acc_rise[1], acc_fall[1]}, 3'b000);

        // Bounce 1,0,1,1,0 then steady 1 on channel 1
        clear_acc();
        btn_i[1] = 1'b1; run(1);
        btn_i[1] = 1'b0; run(1);
        btn_i[1] = 1'b1; run(1);
        btn_i[1] = 1'b1; run(1);
        btn_i[1] = 1'b0; run(1);
        btn_i[1] = 1'b1;
        run(5);
        check("bounce_no_early_rise", n_rise1, 0);
        check("bounce_level_e5",      level_o[1], 1'b0);
        run(1);
        check("bounce_rise_e6", rise_o[1], 1'b1);
        run(8);
        check("bounce_single_rise", n_rise1, 1);

        // Short press on channel 2: level high 8 cycles, then release
        btn_i = 4'h7;
        run(6);
        check("short_level_up", level_o[2], 1'b1);
        check("short_rise",     rise_o[2],  1'b1);
        clear_acc();
        run(2);
        btn_i = 4'h3;
        run(5);
        check("short_fall_e5",  fall_o[2],  1'b0);
        check("short_level_e5", level_o[2], 1'b1);
        run(1);
        check("short_fall_e6",  fall_o[2],  1'b1);
        check("short_level_e6", level_o[2], 1'b0);
        run(1);
        check("short_fall_e7", fall_o[2], 1'b0);
        run(10);
        check("short_no_hold", acc_hold[2], 1'b0);

        // Channel 3 rises while channel 0 falls
        btn_i = 4'hA;
        run(5);
        check("simul_rise_e5", rise_o, 4'h0);
        check("simul_fall_e5", fall_o, 4'h0);
        run(1);
        check("simul_rise_e6", rise_o, 4'h8);
        check("simul_fall_e6", fall_o, 4'h1);
        run(1);
        check("simul_rise_e7", rise_o, 4'h0);
        check("simul_fall_e7", fall_o, 4'h0);

        // Reset while channels 1 and 3 are mid-count toward release
        btn_i = 4'h0;
        run(4);
        check("midcnt_level", level_o, 4'hA);
        arst_i = 1'b1;
        #1;
        check("midcnt_rst_level", level_o, 4'h0);
        run(2);
        arst_i = 1'b0;
        clear_acc();
        run(12);
        check("midcnt_quiet", acc_level | acc_rise | acc_fall | acc_hold, 4'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
